// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing (50 MHz / 9600 baud).
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  localparam int unsigned UART_CLKS_PER_BIT = 5208;
endpackage

// File: rtl/rx_edge_detect.sv
// RX pin synchroniser with a third history flop for high-to-low edge detection.
module rx_edge_detect (
  input  logic CLK,
  input  logic RSTn,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic h2l_o
);
  logic sync1_q, sync2_q, sync3_q;

  // Flops reset high (line idle level) so leaving reset never looks like a start edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rx_sync_o = sync2_q;
  assign h2l_o     = ~sync2_q & sync3_q;
endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receive core: start detect, mid-bit sampling, byte delivery with done/error pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       RX_Pin_In,
  input  logic       RX_En_Sig,
  output logic       RX_Done_Sig,
  output logic [7:0] RX_Data,
  output logic       RX_Err_Sig
);
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

  logic             rx_sync, h2l;
  uart_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             done_q, err_q;

  rx_edge_detect u_edge (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .rx_i     (RX_Pin_In),
    .rx_sync_o(rx_sync),
    .h2l_o    (h2l)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          bit_cnt_q <= '0;
          if (h2l && RX_En_Sig) state_q <= START;
        end
        START: begin
          if (!RX_En_Sig) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == HALF_END) begin
            cnt_q   <= '0;
            state_q <= rx_sync ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (!RX_En_Sig) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == BIT_END) begin
            cnt_q              <= '0;
            shift_q[bit_cnt_q] <= rx_sync;
            bit_cnt_q          <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          // Enable loss wins over a stop sample in the same cycle.
          if (!RX_En_Sig) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == BIT_END) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_sync) begin
              data_q <= shift_q;
              done_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RX_Done_Sig = done_q;
  assign RX_Err_Sig  = err_q;
  assign RX_Data     = data_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: frame table plus hand-written corner sequences.
module tb_uart_rx_core;
  localparam int unsigned CPB = 16;
  // Pin driven mid-cycle: two synchroniser edges to H2L, then HALF_BIT + 9*CPB + 1.
  localparam int unsigned LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       RX_Pin_In = 1'b1;
  logic       RX_En_Sig = 1'b1;
  logic       RX_Done_Sig;
  logic [7:0] RX_Data;
  logic       RX_Err_Sig;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int unsigned done_last = 0;
  int unsigned done_prev = 0;

  typedef struct {
    logic        is_err;
    logic [7:0]  data;
    int unsigned cyc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       en;
    int         kind;   // 0 none, 1 done, 2 err
    logic [7:0] exp_q;  // RX_Data expected after the frame
  } vec_t;
  vec_t vecs[5];

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .RX_Pin_In  (RX_Pin_In),
    .RX_En_Sig  (RX_En_Sig),
    .RX_Done_Sig(RX_Done_Sig),
    .RX_Data    (RX_Data),
    .RX_Err_Sig (RX_Err_Sig)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Called on a negedge; leaves the line high on a negedge after the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int kind,
                            input logic [7:0] exp_data);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX_Pin_In = frame[i];
      if (i == 0 && kind != 0) sb.push_back('{(kind == 2), exp_data, cyc + LAT});
      repeat (CPB) @(negedge CLK);
    end
    RX_Pin_In = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (RX_Done_Sig || RX_Err_Sig) begin
      sb_t e;
      total++;
      if (RX_Done_Sig && RX_Err_Sig) begin
        bad++;
        $display("FAIL pulse_excl: done and err both high at cycle %0d", cyc);
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b data=%h at cycle %0d",
                 RX_Done_Sig, RX_Err_Sig, RX_Data, cyc);
      end else begin
        e = sb.pop_front();
        if (e.is_err !== RX_Err_Sig || e.data !== RX_Data || e.cyc != cyc) begin
          bad++;
          $display("FAIL pulse: got err=%0b data=%h cycle=%0d want err=%0b data=%h cycle=%0d",
                   RX_Err_Sig, RX_Data, cyc, e.is_err, e.data, e.cyc);
        end
      end
      if (RX_Done_Sig) begin
        done_prev = done_last;
        done_last = cyc;
      end
    end
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 2, 8'hA5};
    vecs[2] = '{8'h55, 1'b1, 1'b0, 0, 8'hA5};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1, 8'h00};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 1, 8'h81};

    repeat (3) @(negedge CLK);
    check("reset_done", 32'(RX_Done_Sig), 32'd0);
    check("reset_err", 32'(RX_Err_Sig), 32'd0);
    check("reset_data", 32'(RX_Data), 32'h00);
    RSTn = 1'b1;
    repeat (5) @(negedge CLK);

    for (int v = 0; v < 5; v++) begin
      logic [7:0] prev;
      prev = (v == 0) ? 8'h00 : vecs[v-1].exp_q;
      RX_En_Sig = vecs[v].en;
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].kind,
                 (vecs[v].kind == 1) ? vecs[v].data : prev);
      RX_En_Sig = 1'b1;
      repeat (2 * CPB) @(negedge CLK);
      check($sformatf("vec%0d_data", v), 32'(RX_Data), 32'(vecs[v].exp_q));
    end

    // Glitch shorter than half a bit: false start.
    RX_Pin_In = 1'b0;
    repeat (6) @(negedge CLK);
    RX_Pin_In = 1'b1;
    repeat (3 * CPB) @(negedge CLK);
    check("glitch_data", 32'(RX_Data), 32'h81);

    // Framing error with the line then held low must not retrigger.
    send_frame(8'h00, 1'b0, 2, 8'h81);
    RX_Pin_In = 1'b0;
    repeat (3 * CPB) @(negedge CLK);
    RX_Pin_In = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
    check("held_low_data", 32'(RX_Data), 32'h81);

    // Enable dropped during data bit 4.
    fork
      send_frame(8'hFF, 1'b1, 0, 8'h00);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge CLK);
        RX_En_Sig = 1'b0;
        repeat (3) @(negedge CLK);
        RX_En_Sig = 1'b1;
      end
    join
    repeat (2 * CPB) @(negedge CLK);
    check("abort_data", 32'(RX_Data), 32'h81);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, 1, 8'h00);
    send_frame(8'hFF, 1'b1, 1, 8'hFF);
    repeat (2 * CPB) @(negedge CLK);
    check("b2b_spacing", done_last - done_prev, 10 * CPB);
    check("b2b_data", 32'(RX_Data), 32'hFF);

    // Asynchronous reset in the middle of the data bits.
    fork
      send_frame(8'h5A, 1'b1, 0, 8'h00);
      begin
        repeat (3 * CPB) @(negedge CLK);
        #2 RSTn = 1'b0;
        #1;
        check("midrst_done", 32'(RX_Done_Sig), 32'd0);
        check("midrst_err", 32'(RX_Err_Sig), 32'd0);
        check("midrst_data", 32'(RX_Data), 32'h00);
      end
    join
    repeat (4) @(negedge CLK);
    RSTn = 1'b1;
    repeat (4) @(negedge CLK);
    send_frame(8'h5A, 1'b1, 1, 8'h5A);
    repeat (2 * CPB) @(negedge CLK);
    check("post_rst_data", 32'(RX_Data), 32'h5A);

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
